// File: rtl/trans_tlb.sv
// trans_tlb: fully associative MIPS-style joint TLB with NUM_PORTS one-cycle lookup ports.
// Optional probe port (TLBP-style index search) is built when TRANS_TLB_PROBE_EN is defined.
module trans_tlb #(
  parameter  int NUM_ENTRIES = 8,
  parameter  int NUM_PORTS   = 2,
  localparam int IDX_W       = $clog2(NUM_ENTRIES)
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic [NUM_PORTS-1:0]       req_valid,
  input  logic [NUM_PORTS-1:0][31:0] req_vaddr,
  input  logic [NUM_PORTS-1:0]       req_store,
  input  logic [7:0]                 asid,
  input  logic                       k0_uncached,
  output logic [NUM_PORTS-1:0]       resp_valid,
  output logic [NUM_PORTS-1:0]       resp_uncached,
  output logic [NUM_PORTS-1:0]       resp_refill,
  output logic [NUM_PORTS-1:0]       resp_invalid,
  output logic [NUM_PORTS-1:0]       resp_modified,
  output logic [NUM_PORTS-1:0][31:0] resp_paddr,
  input  logic                       tlb_we,
  input  logic [IDX_W-1:0]           tlb_windex,
  input  logic [77:0]                tlb_wentry,
  input  logic [IDX_W-1:0]           tlb_rindex,
  output logic [77:0]                tlb_rentry
`ifdef TRANS_TLB_PROBE_EN
  ,
  input  logic                       probe_valid,
  input  logic [18:0]                probe_vpn2,
  output logic                       probe_done,
  output logic                       probe_hit,
  output logic [IDX_W-1:0]           probe_index
`endif
);

  typedef struct packed {
    logic [18:0] vpn2;
    logic [7:0]  asid;
    logic        g;
    logic [19:0] pfn0;
    logic [2:0]  c0;
    logic        d0;
    logic        v0;
    logic [19:0] pfn1;
    logic [2:0]  c1;
    logic        d1;
    logic        v1;
  } tlb_entry_t;

  function automatic logic entry_hit(input tlb_entry_t e, input logic [18:0] vpn2,
                                     input logic [7:0] cur_asid);
    return (e.vpn2 == vpn2) && (e.g || (e.asid == cur_asid));
  endfunction

  // Scanning downwards leaves the lowest matching index, so duplicates resolve silently.
  function automatic logic [IDX_W-1:0] lowest_idx(input logic [NUM_ENTRIES-1:0] m);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (m[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

  tlb_entry_t                           entry_q [NUM_ENTRIES];
  tlb_entry_t                           sel_entry [NUM_PORTS];
  logic [NUM_PORTS-1:0][NUM_ENTRIES-1:0] match;
  logic [77:0]                          rentry_q;

  logic [NUM_PORTS-1:0]       valid_d, valid_q;
  logic [NUM_PORTS-1:0]       uncached_d, uncached_q;
  logic [NUM_PORTS-1:0]       refill_d, refill_q;
  logic [NUM_PORTS-1:0]       invalid_d, invalid_q;
  logic [NUM_PORTS-1:0]       modified_d, modified_q;
  logic [NUM_PORTS-1:0][31:0] paddr_d, paddr_q;

  // Entry storage: a write lands at the edge, so same-cycle lookups and reads see old contents.
  // NOTE: the entry array is reset explicitly because reset must invalidate every mapping;
  // this keeps it in flops rather than a RAM macro, which is fine at 2..32 entries.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < NUM_ENTRIES; i++) entry_q[i] <= '0;
      rentry_q <= '0;
    end else begin
      if (tlb_we) entry_q[tlb_windex] <= tlb_wentry;
      rentry_q <= entry_q[tlb_rindex];
    end
  end

  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        match[p][i] = entry_hit(entry_q[i], req_vaddr[p][31:13], asid);
      end
      sel_entry[p] = entry_q[lowest_idx(match[p])];
    end
  end

  // NOTE: every output of this block gets a default before any branch, so no latch is inferred.
  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      valid_d[p]    = req_valid[p];
      uncached_d[p] = 1'b0;
      refill_d[p]   = 1'b0;
      invalid_d[p]  = 1'b0;
      modified_d[p] = 1'b0;
      paddr_d[p]    = '0;
      if (req_valid[p]) begin
        case (req_vaddr[p][31:29])
          3'b100: begin
            paddr_d[p]    = {3'b000, req_vaddr[p][28:0]};
            uncached_d[p] = k0_uncached;
          end
          3'b101: begin
            paddr_d[p]    = {3'b000, req_vaddr[p][28:0]};
            uncached_d[p] = 1'b1;
          end
          default: begin
            if (match[p] == '0) begin
              refill_d[p] = 1'b1;
            end else if (!(req_vaddr[p][12] ? sel_entry[p].v1 : sel_entry[p].v0)) begin
              invalid_d[p] = 1'b1;
            end else begin
              paddr_d[p] = {(req_vaddr[p][12] ? sel_entry[p].pfn1 : sel_entry[p].pfn0),
                            req_vaddr[p][11:0]};
              uncached_d[p] = ((req_vaddr[p][12] ? sel_entry[p].c1 : sel_entry[p].c0) == 3'd2);
              modified_d[p] = req_store[p] &
                              ~(req_vaddr[p][12] ? sel_entry[p].d1 : sel_entry[p].d0);
            end
          end
        endcase
      end
    end
  end

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      valid_q    <= '0;
      uncached_q <= '0;
      refill_q   <= '0;
      invalid_q  <= '0;
      modified_q <= '0;
      paddr_q    <= '0;
    end else begin
      valid_q    <= valid_d;
      uncached_q <= uncached_d;
      refill_q   <= refill_d;
      invalid_q  <= invalid_d;
      modified_q <= modified_d;
      paddr_q    <= paddr_d;
    end
  end

  assign resp_valid    = valid_q;
  assign resp_uncached = uncached_q;
  assign resp_refill   = refill_q;
  assign resp_invalid  = invalid_q;
  assign resp_modified = modified_q;
  assign resp_paddr    = paddr_q;
  assign tlb_rentry    = rentry_q;

`ifdef TRANS_TLB_PROBE_EN
  logic [NUM_ENTRIES-1:0] probe_match;
  logic                   probe_done_q, probe_hit_q;
  logic [IDX_W-1:0]       probe_index_q;

  always_comb begin
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      probe_match[i] = entry_hit(entry_q[i], probe_vpn2, asid);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      probe_done_q  <= 1'b0;
      probe_hit_q   <= 1'b0;
      probe_index_q <= '0;
    end else begin
      probe_done_q  <= probe_valid;
      probe_hit_q   <= probe_valid && (probe_match != '0);
      probe_index_q <= (probe_valid && (probe_match != '0)) ? lowest_idx(probe_match) : '0;
    end
  end

  assign probe_done  = probe_done_q;
  assign probe_hit   = probe_hit_q;
  assign probe_index = probe_index_q;
`endif

endmodule

// File: tb/tb_trans_tlb.sv
// tb_trans_tlb: directed scenarios plus randomized traffic checked against a behavioural TLB model.
// Probe checks are compiled in when TRANS_TLB_PROBE_EN is defined.
module tb_trans_tlb;

  localparam int NE = 8;

  logic             clk;
  logic             resetn;
  logic [1:0]       req_valid;
  logic [1:0][31:0] req_vaddr;
  logic [1:0]       req_store;
  logic [7:0]       asid;
  logic             k0_uncached;
  logic [1:0]       resp_valid, resp_uncached, resp_refill, resp_invalid, resp_modified;
  logic [1:0][31:0] resp_paddr;
  logic             tlb_we;
  logic [2:0]       tlb_windex;
  logic [77:0]      tlb_wentry;
  logic [2:0]       tlb_rindex;
  logic [77:0]      tlb_rentry;
`ifdef TRANS_TLB_PROBE_EN
  logic             probe_valid;
  logic [18:0]      probe_vpn2;
  logic             probe_done, probe_hit;
  logic [2:0]       probe_index;
`endif

  trans_tlb #(.NUM_ENTRIES(NE), .NUM_PORTS(2)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .req_valid    (req_valid),
    .req_vaddr    (req_vaddr),
    .req_store    (req_store),
    .asid         (asid),
    .k0_uncached  (k0_uncached),
    .resp_valid   (resp_valid),
    .resp_uncached(resp_uncached),
    .resp_refill  (resp_refill),
    .resp_invalid (resp_invalid),
    .resp_modified(resp_modified),
    .resp_paddr   (resp_paddr),
    .tlb_we       (tlb_we),
    .tlb_windex   (tlb_windex),
    .tlb_wentry   (tlb_wentry),
    .tlb_rindex   (tlb_rindex),
    .tlb_rentry   (tlb_rentry)
`ifdef TRANS_TLB_PROBE_EN
    ,
    .probe_valid  (probe_valid),
    .probe_vpn2   (probe_vpn2),
    .probe_done   (probe_done),
    .probe_hit    (probe_hit),
    .probe_index  (probe_index)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  logic [77:0] mem [NE];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [77:0] mk_entry(
      input logic [18:0] vpn2, input logic [7:0] a, input logic g,
      input logic [19:0] pfn0, input logic [2:0] c0, input logic d0, input logic v0,
      input logic [19:0] pfn1, input logic [2:0] c1, input logic d1, input logic v1);
    return {vpn2, a, g, pfn0, c0, d0, v0, pfn1, c1, d1, v1};
  endfunction

  // Expected response as {valid, uncached, refill, invalid, modified, paddr}.
  function automatic logic [36:0] model_resp(input logic vld, input logic [31:0] va, input logic st);
    logic [77:0] e;
    logic [19:0] pfn;
    logic [2:0]  c;
    logic        d, v;
    if (!vld) return '0;
    if (va[31:29] == 3'b100) return {1'b1, k0_uncached, 3'b000, 3'b000, va[28:0]};
    if (va[31:29] == 3'b101) return {1'b1, 1'b1, 3'b000, 3'b000, va[28:0]};
    for (int i = 0; i < NE; i++) begin
      e = mem[i];
      if (e[77:59] == va[31:13] && (e[50] || e[58:51] == asid)) begin
        pfn = va[12] ? e[24:5] : e[49:30];
        c   = va[12] ? e[4:2]  : e[29:27];
        d   = va[12] ? e[1]    : e[26];
        v   = va[12] ? e[0]    : e[25];
        if (!v) return {1'b1, 1'b0, 3'b010, 32'h0};
        return {1'b1, (c == 3'd2), 2'b00, (st && !d), pfn, va[11:0]};
      end
    end
    return {1'b1, 1'b0, 3'b100, 32'h0};
  endfunction

  // One clock: predict from pre-edge inputs and model, update the model, compare after the edge.
  task automatic step();
    logic [36:0] exp_r [2];
    logic [77:0] exp_re;
    logic [4:0]  exp_probe;
    for (int p = 0; p < 2; p++) begin
      exp_r[p] = resetn ? model_resp(req_valid[p], req_vaddr[p], req_store[p]) : '0;
    end
    exp_re    = resetn ? mem[tlb_rindex] : '0;
    exp_probe = '0;
`ifdef TRANS_TLB_PROBE_EN
    if (resetn && probe_valid) begin
      exp_probe = 5'b10000;
      for (int i = NE - 1; i >= 0; i--) begin
        if (mem[i][77:59] == probe_vpn2 && (mem[i][50] || mem[i][58:51] == asid))
          exp_probe = {2'b11, 3'(i)};
      end
    end
`endif
    if (!resetn) begin
      for (int i = 0; i < NE; i++) mem[i] = '0;
    end else if (tlb_we) begin
      mem[tlb_windex] = tlb_wentry;
    end
    @(posedge clk);
    #1;
    for (int p = 0; p < 2; p++) begin
      check($sformatf("resp%0d", p),
            {resp_valid[p], resp_uncached[p], resp_refill[p], resp_invalid[p],
             resp_modified[p], resp_paddr[p]}, exp_r[p]);
    end
    check("rentry", tlb_rentry, exp_re);
`ifdef TRANS_TLB_PROBE_EN
    check("probe", {probe_done, probe_hit, probe_index}, exp_probe);
`endif
  endtask

  task automatic idle();
    req_valid = '0;
    req_store = '0;
    tlb_we    = 1'b0;
`ifdef TRANS_TLB_PROBE_EN
    probe_valid = 1'b0;
`endif
  endtask

  function automatic logic [18:0] pick_vpn2();
    case ($urandom_range(0, 5))
      0:       return 19'h00200;
      1:       return 19'h7FFFF;
      2:       return 19'h2ABCD;
      3:       return 19'h40010;
      4:       return 19'h50001;
      default: return 19'($urandom);
    endcase
  endfunction

  function automatic logic [77:0] rand_entry();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return {pick_vpn2(), ($urandom_range(0, 1) != 0) ? 8'h05 : 8'h06, 1'($urandom), r[54:0]};
  endfunction

  initial begin
    logic [77:0] e3;
    resetn      = 1'b0;
    idle();
    asid        = 8'h00;
    k0_uncached = 1'b0;
    req_vaddr   = '0;
    tlb_windex  = '0;
    tlb_wentry  = '0;
    tlb_rindex  = '0;
`ifdef TRANS_TLB_PROBE_EN
    probe_vpn2  = '0;
`endif
    for (int i = 0; i < NE; i++) mem[i] = '0;
    step();
    step();
    resetn = 1'b1;

    // Unmapped segments.
    k0_uncached  = 1'b1;
    req_valid    = 2'b01;
    req_vaddr[0] = 32'h8000_1234;
    step();
    check("k0_paddr", resp_paddr[0], 32'h0000_1234);
    check("k0_flags", {resp_uncached[0], resp_refill[0], resp_invalid[0], resp_modified[0]}, 4'b1000);
    req_vaddr[0] = 32'hBFC0_0000;
    step();
    check("k1_paddr", resp_paddr[0], 32'h1FC0_0000);

    // Mapped hit, ASID mismatch, invalid odd page.
    idle();
    e3 = mk_entry(19'h00200, 8'h05, 1'b0, 20'h12345, 3'd3, 1'b1, 1'b1, 20'h0, 3'd0, 1'b0, 1'b0);
    tlb_we = 1'b1; tlb_windex = 3'd3; tlb_wentry = e3; asid = 8'h05;
    step();
    idle();
    req_valid = 2'b10; req_vaddr[1] = 32'h0040_0ABC; tlb_rindex = 3'd3;
`ifdef TRANS_TLB_PROBE_EN
    probe_valid = 1'b1; probe_vpn2 = 19'h00200;
`endif
    step();
    check("map_paddr", resp_paddr[1], 32'h1234_5ABC);
    check("map_uncached", resp_uncached[1], 1'b0);
    check("rentry3", tlb_rentry, e3);
`ifdef TRANS_TLB_PROBE_EN
    check("probe_hit3", {probe_done, probe_hit, probe_index}, {2'b11, 3'd3});
    probe_vpn2 = 19'h12345;
`endif
    asid = 8'h06;
    step();
    check("asid_refill", resp_refill[1], 1'b1);
`ifdef TRANS_TLB_PROBE_EN
    check("probe_miss", {probe_done, probe_hit}, 2'b10);
`endif
    asid = 8'h05; req_vaddr[1] = 32'h0040_1000;
    step();
    check("odd_invalid", resp_invalid[1], 1'b1);

    // Store to a clean page.
    idle();
    tlb_we = 1'b1; tlb_windex = 3'd3;
    tlb_wentry = mk_entry(19'h00200, 8'h05, 1'b0, 20'h12345, 3'd3, 1'b0, 1'b1, 20'h0, 3'd0, 1'b0, 1'b0);
    step();
    idle();
    req_valid = 2'b01; req_store = 2'b01; req_vaddr[0] = 32'h0040_0000;
    step();
    check("store_modified", resp_modified[0], 1'b1);
    check("store_paddr", resp_paddr[0], 32'h1234_5000);

    // Duplicate global entries: lowest index wins.
    idle();
    tlb_we = 1'b1; tlb_windex = 3'd1;
    tlb_wentry = mk_entry(19'h7FFFF, 8'h00, 1'b1, 20'h00011, 3'd3, 1'b1, 1'b1, 20'h0, 3'd0, 1'b0, 1'b0);
    step();
    tlb_windex = 3'd5;
    tlb_wentry = mk_entry(19'h7FFFF, 8'h00, 1'b1, 20'h00055, 3'd3, 1'b1, 1'b1, 20'h0, 3'd0, 1'b0, 1'b0);
    step();
    idle();
    req_valid = 2'b11; req_vaddr[0] = 32'hFFFF_E004; req_vaddr[1] = 32'hFFFF_E004;
    step();
    check("multi_paddr", resp_paddr[0], 32'h0001_1004);

    // Same-cycle rewrite of the matched entry, then reset mid-stream.
    tlb_we = 1'b1; tlb_windex = 3'd1;
    tlb_wentry = mk_entry(19'h7FFFF, 8'h00, 1'b1, 20'h00077, 3'd3, 1'b1, 1'b1, 20'h0, 3'd0, 1'b0, 1'b0);
    step();
    check("same_cycle_old", resp_paddr[1], 32'h0001_1004);
    tlb_we = 1'b0;
    step();
    check("next_cycle_new", resp_paddr[1], 32'h0007_7004);
    resetn = 1'b0;
    step();
    check("reset_drop", resp_valid, 2'b00);
    resetn = 1'b1;
    step();
    check("reset_miss", resp_refill, 2'b11);

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      resetn = ($urandom_range(0, 63) != 0);
      if ($urandom_range(0, 7) == 0) asid = ($urandom_range(0, 1) != 0) ? 8'h05 : 8'h06;
      k0_uncached = 1'($urandom);
      for (int p = 0; p < 2; p++) begin
        req_valid[p] = 1'($urandom);
        req_store[p] = 1'($urandom);
        req_vaddr[p] = {pick_vpn2(), 13'($urandom)};
      end
      tlb_we     = ($urandom_range(0, 3) == 0);
      tlb_windex = 3'($urandom);
      tlb_wentry = rand_entry();
      tlb_rindex = 3'($urandom);
`ifdef TRANS_TLB_PROBE_EN
      probe_valid = 1'($urandom);
      probe_vpn2  = pick_vpn2();
`endif
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
